// File: rtl/wb_line_master.sv
// Wishbone B4 line-transfer master: wrapping critical-word-first bursts, define WBM_BURST_EN for registered bursts.
// Latency: cyc/stb one cycle after accept, rsp one cycle after each ack; back-pressure via req_ready (IDLE only) and wd_pop.
module wb_line_master #(
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [31:0] wd_data,
   output logic        wd_pop,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_last,
   output logic        rsp_err,
   output logic [31:0] dwbm_addr,
   output logic [31:0] dwbm_dat_w,
   output logic [3:0]  dwbm_sel,
   output logic        dwbm_cyc,
   output logic        dwbm_stb,
   output logic [2:0]  dwbm_cti,
   output logic [1:0]  dwbm_bte,
   output logic        dwbm_we,
   input  logic [31:0] dwbm_dat_r,
   input  logic        dwbm_ack,
   input  logic        dwbm_err
);

   localparam int IW = $clog2(LINE_WORDS);

`ifdef WBM_BURST_EN
   localparam logic [1:0] BTE     = (LINE_WORDS == 4) ? 2'b01 : (LINE_WORDS == 8) ? 2'b10 : 2'b11;
   localparam logic [2:0] CTI_INC = 3'b010;
   localparam logic [2:0] CTI_END = 3'b111;
   localparam logic       BURST   = 1'b1;
`else
   localparam logic [1:0] BTE     = 2'b00;
   localparam logic [2:0] CTI_INC = 3'b000;
   localparam logic [2:0] CTI_END = 3'b000;
   localparam logic       BURST   = 1'b0;
`endif

   typedef enum logic {IDLE, BUS} state_t;
   state_t state;

   logic [IW-1:0] beat;
   logic [IW-1:0] idx_nxt;
   logic          last_beat;
   logic          take;
   logic          bus_ack;
   logic          bus_err;
   logic          unused_addr;

   assign unused_addr = ^req_addr[1:0];

   assign last_beat  = &beat;
   assign idx_nxt    = dwbm_addr[IW+1:2] + IW'(1);
   assign take       = (state == BUS) && dwbm_cyc && dwbm_stb;
   // err dominates ack when both arrive together
   assign bus_err    = take && dwbm_err;
   assign bus_ack    = take && dwbm_ack && !dwbm_err;

   assign req_ready  = (state == IDLE);
   assign dwbm_dat_w = wd_data;
   assign dwbm_sel   = 4'hF;
   assign dwbm_bte   = dwbm_cyc ? BTE : 2'b00;
   assign wd_pop     = dwbm_ack & dwbm_cyc & dwbm_stb & dwbm_we & ~dwbm_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dwbm_cyc  <= 1'b0;
         dwbm_stb  <= 1'b0;
         dwbm_we   <= 1'b0;
         dwbm_cti  <= 3'b000;
         dwbm_addr <= 32'h0;
         beat      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'h0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= BUS;
                  dwbm_cyc  <= 1'b1;
                  dwbm_stb  <= 1'b1;
                  dwbm_we   <= req_we;
                  dwbm_addr <= {req_addr[31:2], 2'b00};
                  dwbm_cti  <= CTI_INC;
                  beat      <= '0;
               end
            end
            BUS: begin
               if (bus_err) begin
                  state     <= IDLE;
                  dwbm_cyc  <= 1'b0;
                  dwbm_stb  <= 1'b0;
                  dwbm_cti  <= 3'b000;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_last  <= 1'b1;
               end else if (bus_ack) begin
                  rsp_valid <= ~dwbm_we;
                  rsp_last  <= last_beat & ~dwbm_we;
                  if (!dwbm_we)
                     rsp_data <= dwbm_dat_r;
                  if (last_beat) begin
                     state    <= IDLE;
                     dwbm_cyc <= 1'b0;
                     dwbm_stb <= 1'b0;
                     dwbm_cti <= 3'b000;
                  end else begin
                     // only the word index wraps; the line base stays put
                     beat                <= beat + IW'(1);
                     dwbm_addr[IW+1:2]   <= idx_nxt;
                     dwbm_cti            <= (beat == IW'(LINE_WORDS - 2)) ? CTI_END : CTI_INC;
                     dwbm_stb            <= BURST;
                  end
               end else if (!dwbm_stb) begin
                  dwbm_stb <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_line_master.sv
// Directed bench for wb_line_master: 4-word instance for reads/errors/resets, 8-word instance for writes.
module tb_wb_line_master;

`ifdef WBM_BURST_EN
   localparam logic [2:0] E_CTI_I = 3'b010;
   localparam logic [2:0] E_CTI_E = 3'b111;
   localparam logic [1:0] E_BTE4  = 2'b01;
   localparam logic [1:0] E_BTE8  = 2'b10;
   localparam int         E_GAPS4 = 0;
`else
   localparam logic [2:0] E_CTI_I = 3'b000;
   localparam logic [2:0] E_CTI_E = 3'b000;
   localparam logic [1:0] E_BTE4  = 2'b00;
   localparam logic [1:0] E_BTE8  = 2'b00;
   localparam int         E_GAPS4 = 3;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic        req_valid, req_ready, req_we, wd_pop, rsp_valid, rsp_last, rsp_err;
   logic [31:0] req_addr, wd_data, rsp_data, dwbm_addr, dwbm_dat_w, dwbm_dat_r;
   logic [3:0]  dwbm_sel;
   logic        dwbm_cyc, dwbm_stb, dwbm_we, dwbm_ack, dwbm_err;
   logic [2:0]  dwbm_cti;
   logic [1:0]  dwbm_bte;

   logic        req_valid_8, req_ready_8, req_we_8, wd_pop_8, rsp_valid_8, rsp_last_8, rsp_err_8;
   logic [31:0] req_addr_8, wd_data_8, rsp_data_8, dwbm_addr_8, dwbm_dat_w_8, dwbm_dat_r_8;
   logic [3:0]  dwbm_sel_8;
   logic        dwbm_cyc_8, dwbm_stb_8, dwbm_we_8, dwbm_ack_8, dwbm_err_8;
   logic [2:0]  dwbm_cti_8;
   logic [1:0]  dwbm_bte_8;

   wb_line_master #(.LINE_WORDS(4)) u4 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .wd_data(wd_data), .wd_pop(wd_pop), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err), .dwbm_addr(dwbm_addr),
      .dwbm_dat_w(dwbm_dat_w), .dwbm_sel(dwbm_sel), .dwbm_cyc(dwbm_cyc), .dwbm_stb(dwbm_stb),
      .dwbm_cti(dwbm_cti), .dwbm_bte(dwbm_bte), .dwbm_we(dwbm_we), .dwbm_dat_r(dwbm_dat_r),
      .dwbm_ack(dwbm_ack), .dwbm_err(dwbm_err));

   wb_line_master #(.LINE_WORDS(8)) u8 (
      .clk(clk), .rst(rst), .req_valid(req_valid_8), .req_ready(req_ready_8), .req_addr(req_addr_8),
      .req_we(req_we_8), .wd_data(wd_data_8), .wd_pop(wd_pop_8), .rsp_valid(rsp_valid_8),
      .rsp_data(rsp_data_8), .rsp_last(rsp_last_8), .rsp_err(rsp_err_8), .dwbm_addr(dwbm_addr_8),
      .dwbm_dat_w(dwbm_dat_w_8), .dwbm_sel(dwbm_sel_8), .dwbm_cyc(dwbm_cyc_8), .dwbm_stb(dwbm_stb_8),
      .dwbm_cti(dwbm_cti_8), .dwbm_bte(dwbm_bte_8), .dwbm_we(dwbm_we_8), .dwbm_dat_r(dwbm_dat_r_8),
      .dwbm_ack(dwbm_ack_8), .dwbm_err(dwbm_err_8));

   int n_checks = 0;
   int n_fail   = 0;

   // observations gathered by the 4-word slave driver
   logic [31:0] obs_addr [16];
   logic [2:0]  obs_cti  [16];
   logic [1:0]  obs_bte;
   logic [31:0] rsp_d    [16];
   logic        rsp_l    [16];
   logic        rsp_e    [16];
   int          nb, nrsp, npop, gaps, stable_bad;
   logic        timeout;
   logic [2:0]  rst_seen;

   task automatic run4(input logic [31:0] a, input logic we, input int waits,
                       input int err_beat, input int rst_beat);
      int w, cnt;
      logic rst_done;
      logic [42:0] snap;
      nb = 0; nrsp = 0; npop = 0; gaps = 0; stable_bad = 0; timeout = 1'b0;
      rst_seen = 3'b111; w = 0; cnt = 0; rst_done = 1'b0; snap = '0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = a; req_we = we;
      @(negedge clk);
      req_valid = 1'b0;
      while (1) begin
         if (rsp_valid) begin
            rsp_d[nrsp] = rsp_data; rsp_l[nrsp] = rsp_last; rsp_e[nrsp] = rsp_err;
            nrsp++;
         end
         if (!dwbm_cyc) break;
         if (cnt > 200) begin timeout = 1'b1; break; end
         dwbm_ack = 1'b0; dwbm_err = 1'b0; dwbm_dat_r = 32'hDEAD_BEEF;
         if (dwbm_stb) begin
            if (w == 0) snap = {dwbm_addr, dwbm_cti, dwbm_bte, dwbm_sel, dwbm_we, dwbm_cyc};
            else if (snap !== {dwbm_addr, dwbm_cti, dwbm_bte, dwbm_sel, dwbm_we, dwbm_cyc}) stable_bad++;
            if (w < waits) w++;
            else begin
               w = 0;
               if (nb == rst_beat && !rst_done) begin
                  rst = 1'b1; rst_done = 1'b1;
               end else begin
                  if (nb == 0) obs_bte = dwbm_bte;
                  obs_addr[nb] = dwbm_addr; obs_cti[nb] = dwbm_cti;
                  dwbm_ack = 1'b1; dwbm_err = (nb == err_beat);
                  dwbm_dat_r = 32'hDA7A_0000 ^ dwbm_addr;
                  #1;
                  if (wd_pop) npop++;
                  nb++;
               end
            end
         end else gaps++;
         @(negedge clk);
         cnt++;
         if (rst) begin
            rst = 1'b0;
            rst_seen = {dwbm_cyc, dwbm_stb, rsp_valid};
         end
      end
      dwbm_ack = 1'b0; dwbm_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({req_ready, dwbm_cyc, dwbm_stb, dwbm_we, wd_pop, rsp_valid, rsp_last, rsp_err} !== 8'b1000_0000) begin
         n_fail++;
         $display("FAIL reset_ctrl got %b exp 10000000",
                  {req_ready, dwbm_cyc, dwbm_stb, dwbm_we, wd_pop, rsp_valid, rsp_last, rsp_err});
      end
      n_checks++;
      if ({dwbm_cti, dwbm_addr} !== 35'h0) begin
         n_fail++; $display("FAIL reset_cti_addr got cti %b addr %h exp 000/0", dwbm_cti, dwbm_addr);
      end
      n_checks++;
      if ({req_ready_8, dwbm_cyc_8, dwbm_stb_8, rsp_valid_8} !== 4'b1000) begin
         n_fail++; $display("FAIL reset_u8 got %b exp 1000", {req_ready_8, dwbm_cyc_8, dwbm_stb_8, rsp_valid_8});
      end
   endtask

   // shared body for clean 4-beat reads: addresses, cti, data, last flag, bte, stb gaps
   task automatic check_read4(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3, input int waits);
      logic [31:0] ea [4];
      logic [3:0]  lmask;
      ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e3;
      n_checks++;
      if (timeout !== 1'b0 || nb != 4 || nrsp != 4) begin
         n_fail++; $display("FAIL %s_counts got beats %0d rsps %0d to %0d exp 4 4 0", nm, nb, nrsp, timeout);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (obs_addr[k] !== ea[k]) begin
            n_fail++; $display("FAIL %s_addr[%0d] got %h exp %h", nm, k, obs_addr[k], ea[k]);
         end
         n_checks++;
         if (obs_cti[k] !== ((k == 3) ? E_CTI_E : E_CTI_I)) begin
            n_fail++; $display("FAIL %s_cti[%0d] got %b exp %b", nm, k, obs_cti[k], (k == 3) ? E_CTI_E : E_CTI_I);
         end
         n_checks++;
         if (rsp_d[k] !== (32'hDA7A_0000 ^ ea[k])) begin
            n_fail++; $display("FAIL %s_data[%0d] got %h exp %h", nm, k, rsp_d[k], 32'hDA7A_0000 ^ ea[k]);
         end
      end
      lmask = {rsp_l[3], rsp_l[2], rsp_l[1], rsp_l[0]};
      n_checks++;
      if (lmask !== 4'b1000) begin
         n_fail++; $display("FAIL %s_last got %b exp 1000", nm, lmask);
      end
      n_checks++;
      if (obs_bte !== E_BTE4) begin
         n_fail++; $display("FAIL %s_bte got %b exp %b", nm, obs_bte, E_BTE4);
      end
      n_checks++;
      if (gaps != E_GAPS4) begin
         n_fail++; $display("FAIL %s_gaps got %0d exp %0d", nm, gaps, E_GAPS4);
      end
      n_checks++;
      if (req_ready !== 1'b1 || dwbm_cyc !== 1'b0) begin
         n_fail++; $display("FAIL %s_idle got ready %b cyc %b exp 1 0", nm, req_ready, dwbm_cyc);
      end
      if (waits > 0) begin
         n_checks++;
         if (stable_bad != 0) begin
            n_fail++; $display("FAIL %s_stable got %0d changes exp 0", nm, stable_bad);
         end
      end
   endtask

   task automatic test_read_wrap();
      run4(32'h0000_0008, 1'b0, 0, -1, -1);
      check_read4("rd_wrap", 32'h08, 32'h0C, 32'h00, 32'h04, 0);
   endtask

   task automatic test_wait_states();
      run4(32'h0000_0034, 1'b0, 2, -1, -1);
      check_read4("rd_wait", 32'h34, 32'h38, 32'h3C, 32'h30, 2);
   endtask

   task automatic test_error();
      run4(32'h0000_0040, 1'b0, 0, 1, -1);
      n_checks++;
      if (timeout !== 1'b0 || nb != 2 || nrsp != 2) begin
         n_fail++; $display("FAIL err_rd_counts got beats %0d rsps %0d exp 2 2", nb, nrsp);
      end
      n_checks++;
      if ({rsp_e[0], rsp_l[0], rsp_e[1], rsp_l[1]} !== 4'b0011) begin
         n_fail++; $display("FAIL err_rd_flags got %b exp 0011", {rsp_e[0], rsp_l[0], rsp_e[1], rsp_l[1]});
      end
      n_checks++;
      if (rsp_d[0] !== 32'hDA7A_0040) begin
         n_fail++; $display("FAIL err_rd_data0 got %h exp da7a0040", rsp_d[0]);
      end
      n_checks++;
      if (req_ready !== 1'b1 || dwbm_cyc !== 1'b0 || dwbm_stb !== 1'b0) begin
         n_fail++; $display("FAIL err_rd_idle got ready %b cyc %b stb %b exp 1 0 0", req_ready, dwbm_cyc, dwbm_stb);
      end
      run4(32'h0000_0080, 1'b1, 0, 0, -1);
      n_checks++;
      if (npop != 0 || nrsp != 1 || rsp_e[0] !== 1'b1 || rsp_l[0] !== 1'b1) begin
         n_fail++; $display("FAIL err_wr got pops %0d rsps %0d err %b last %b exp 0 1 1 1", npop, nrsp, rsp_e[0], rsp_l[0]);
      end
   endtask

   task automatic test_reset_mid();
      run4(32'h0000_0000, 1'b0, 0, -1, 0);
      n_checks++;
      if (rst_seen !== 3'b000 || nrsp != 0 || nb != 0) begin
         n_fail++; $display("FAIL rst_mid got cyc/stb/rsp %b rsps %0d beats %0d exp 000 0 0", rst_seen, nrsp, nb);
      end
   endtask

   task automatic test_back_to_back();
      run4(32'h0000_0000, 1'b0, 0, -1, -1);
      check_read4("b2b_a", 32'h00, 32'h04, 32'h08, 32'h0C, 0);
      run4(32'h0000_001F, 1'b0, 0, -1, -1);
      check_read4("b2b_b", 32'h1C, 32'h10, 32'h14, 32'h18, 0);
   endtask

   task automatic test_write8();
      logic [31:0] wa [8];
      logic [31:0] wd [8];
      logic [1:0]  bte0;
      int nw, np, nr, cnt;
      logic pend, to;
      nw = 0; np = 0; nr = 0; cnt = 0; pend = 1'b0; to = 1'b0; bte0 = 2'b00;
      wd_data_8 = 32'd1;
      @(negedge clk);
      req_valid_8 = 1'b1; req_addr_8 = 32'h0000_0100; req_we_8 = 1'b1;
      @(negedge clk);
      req_valid_8 = 1'b0;
      while (1) begin
         if (rsp_valid_8) nr++;
         if (!dwbm_cyc_8) break;
         if (cnt > 200) begin to = 1'b1; break; end
         dwbm_ack_8 = 1'b0;
         if (pend) begin wd_data_8 = wd_data_8 + 32'd1; pend = 1'b0; end
         if (dwbm_stb_8 && nw < 8) begin
            if (nw == 0) bte0 = dwbm_bte_8;
            wa[nw] = dwbm_addr_8; wd[nw] = dwbm_dat_w_8;
            dwbm_ack_8 = 1'b1;
            #1;
            if (wd_pop_8) begin np++; pend = 1'b1; end
            nw++;
         end
         @(negedge clk);
         cnt++;
      end
      dwbm_ack_8 = 1'b0;
      n_checks++;
      if (to !== 1'b0 || nw != 8 || np != 8 || nr != 0) begin
         n_fail++; $display("FAIL wr8_counts got beats %0d pops %0d rsps %0d to %b exp 8 8 0 0", nw, np, nr, to);
      end
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (wa[k] !== 32'h100 + 32'(4 * k) || wd[k] !== 32'(k + 1)) begin
            n_fail++; $display("FAIL wr8_beat[%0d] got addr %h dat %h exp %h %h", k, wa[k], wd[k], 32'h100 + 32'(4 * k), k + 1);
         end
      end
      n_checks++;
      if (bte0 !== E_BTE8 || dwbm_cyc_8 !== 1'b0 || req_ready_8 !== 1'b1) begin
         n_fail++; $display("FAIL wr8_end got bte %b cyc %b ready %b exp %b 0 1", bte0, dwbm_cyc_8, req_ready_8, E_BTE8);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; wd_data = 32'h5555_AAAA;
      dwbm_dat_r = 32'h0; dwbm_ack = 1'b0; dwbm_err = 1'b0;
      req_valid_8 = 1'b0; req_addr_8 = 32'h0; req_we_8 = 1'b0; wd_data_8 = 32'h0;
      dwbm_dat_r_8 = 32'h0; dwbm_ack_8 = 1'b0; dwbm_err_8 = 1'b0;
      test_reset();
      test_read_wrap();
      test_write8();
      test_wait_states();
      test_error();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
